// File: rtl/byte_lane_dmem.sv
// Parametrised byte-lane data memory with a wait-state request/done handshake
// and a lane-select LED view of the last word read.
module byte_lane_dmem #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 6,
    parameter int DEPTH       = 64,
    parameter int LANE_W      = 8,
    parameter int WAIT_CYCLES = 1,
    localparam int LANES      = DATA_W / LANE_W,
    localparam int MUX_W      = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Mem_Read,
    input  logic                Mem_Write,
    input  logic [ADDR_W-1:0]   Mem_Addr,
    input  logic [DATA_W-1:0]   Mem_WData,
    input  logic [DATA_W/8-1:0] Byte_En,
    input  logic [MUX_W-1:0]    MUX,
    output logic [DATA_W-1:0]   Mem_RData,
    output logic                Busy,
    output logic                Done,
    output logic                Err,
    output logic [LANE_W-1:0]   LED
);

    localparam int BYTES    = DATA_W / 8;
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]          state;
    logic [CNT_W-1:0]    wait_cnt;
    logic                op_write;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BYTES-1:0]    be_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                done_q;
    logic                err_q;
    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    logic                in_range;
    logic [IDX_W-1:0]    idx;

    assign in_range = ({1'b0, addr_q} < DEPTH_LIM);
    assign idx      = addr_q[IDX_W-1:0];

    // Done/Err are registered, so they appear the cycle after the DONE state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            op_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Mem_Read ^ Mem_Write) begin
                        op_write <= Mem_Write;
                        addr_q   <= Mem_Addr;
                        wdata_q  <= Mem_WData;
                        be_q     <= Byte_En;
                        wait_cnt <= CNT_W'(CNT_INIT);
                        state    <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                    end else if (Mem_Read && Mem_Write) begin
                        err_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= S_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                S_ACCESS: begin
                    if (in_range) begin
                        if (op_write) begin
                            for (int b = 0; b < BYTES; b++) begin
                                if (be_q[b]) begin
                                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                                end
                            end
                        end else begin
                            rdata_q <= mem[idx];
                        end
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    err_q  <= ~in_range;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Lane values beyond the last real lane fall through to zero.
    always_comb begin
        LED = '0;
        for (int i = 0; i < LANES; i++) begin
            if (MUX == MUX_W'(i)) begin
                LED = rdata_q[i*LANE_W +: LANE_W];
            end
        end
    end

    assign Busy      = (state != S_IDLE);
    assign Done      = done_q;
    assign Err       = err_q;
    assign Mem_RData = rdata_q;

endmodule

// File: tb/tb_byte_lane_dmem.sv
// Scoreboard bench for byte_lane_dmem: a default instance plus a short,
// zero-wait-state instance for range and latency boundaries.
module tb_byte_lane_dmem;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    logic        rd, wr, done, busy, err;
    logic [5:0]  addr;
    logic [31:0] wdata, rdata;
    logic [3:0]  be;
    logic [1:0]  mux;
    logic [7:0]  led;

    logic        b_rd, b_wr, b_done, b_busy, b_err;
    logic [5:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic [3:0]  b_be;
    logic [1:0]  b_mux;
    logic [7:0]  b_led;

    byte_lane_dmem dut (
        .Clk(Clk), .Reset(Reset), .Mem_Read(rd), .Mem_Write(wr), .Mem_Addr(addr),
        .Mem_WData(wdata), .Byte_En(be), .MUX(mux), .Mem_RData(rdata),
        .Busy(busy), .Done(done), .Err(err), .LED(led)
    );

    byte_lane_dmem #(.DEPTH(48), .WAIT_CYCLES(0)) dut2 (
        .Clk(Clk), .Reset(Reset), .Mem_Read(b_rd), .Mem_Write(b_wr), .Mem_Addr(b_addr),
        .Mem_WData(b_wdata), .Byte_En(b_be), .MUX(b_mux), .Mem_RData(b_rdata),
        .Busy(b_busy), .Done(b_done), .Err(b_err), .LED(b_led)
    );

    int checks = 0;
    int errors = 0;

    logic [40:0] exp_q [$];
    logic [31:0] model [64];
    logic [31:0] model_rdata;

    function automatic logic [40:0] pack(input logic [31:0] r, input logic e, input int l);
        return {r, e, l[7:0]};
    endfunction

    // Scoreboard push for the default instance: update the model, queue the expected result.
    task automatic expect_txn(input logic w, input logic [5:0] a, input logic [31:0] d,
                              input logic [3:0] e);
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (e[b]) model[a][8*b +: 8] = d[8*b +: 8];
        end else begin
            model_rdata = model[a];
        end
        exp_q.push_back(pack(model_rdata, 1'b0, 3));
    endtask

    // Issue one request and wait (bounded) for Done; latency counts edges after acceptance.
    task automatic run_req(input bit use2, input logic r, input logic w, input logic [5:0] a,
                           input logic [31:0] d, input logic [3:0] e, output logic [40:0] obs);
        int lat;
        logic [31:0] o_r;
        logic o_e;
        @(negedge Clk);
        if (use2) begin
            b_rd = r; b_wr = w; b_addr = a; b_wdata = d; b_be = e;
        end else begin
            rd = r; wr = w; addr = a; wdata = d; be = e;
        end
        @(negedge Clk);
        rd = 1'b0; wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
        lat = -1; o_r = '0; o_e = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge Clk);
            if ((use2 ? b_done : done) === 1'b1) begin
                lat = k;
                o_e = use2 ? b_err : err;
                o_r = use2 ? b_rdata : rdata;
                break;
            end
        end
        obs = pack(o_r, o_e, lat);
    endtask

    task automatic test_reset();
        logic [40:0] obs, exp;
        Reset = 1'b1;
        #12;
        checks++;
        if ({rdata, busy, done, err, led} !== 43'd0) begin
            errors++;
            $display("FAIL reset_dut: got %h expected 0", {rdata, busy, done, err, led});
        end
        checks++;
        if ({b_rdata, b_busy, b_done, b_err, b_led} !== 43'd0) begin
            errors++;
            $display("FAIL reset_dut2: got %h expected 0", {b_rdata, b_busy, b_done, b_err, b_led});
        end
        @(negedge Clk);
        Reset = 1'b0;
        expect_txn(1'b0, 6'd0, '0, '0);
        run_req(1'b0, 1'b1, 1'b0, 6'd0, '0, '0, obs);
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_read0: got %h expected %h", obs, exp);
        end
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL reset_led: got %h expected 00", led);
        end
    endtask

    task automatic test_full_write();
        logic [40:0] obs, exp;
        logic [31:0] word;
        expect_txn(1'b1, 6'd2, 32'hC33C0F81, 4'hF);
        run_req(1'b0, 1'b0, 1'b1, 6'd2, 32'hC33C0F81, 4'hF, obs);
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL full_write: got %h expected %h", obs, exp);
        end
        expect_txn(1'b0, 6'd2, '0, '0);
        run_req(1'b0, 1'b1, 1'b0, 6'd2, '0, '0, obs);
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL full_read: got %h expected %h", obs, exp);
        end
        word = 32'hC33C0F81;
        for (int m = 0; m < 4; m++) begin
            mux = 2'(m);
            #1;
            checks++;
            if (led !== word[8*m +: 8]) begin
                errors++;
                $display("FAIL lane_%0d: got %h expected %h", m, led, word[8*m +: 8]);
            end
        end
        mux = 2'd0;
    endtask

    task automatic test_byte_enables();
        logic [40:0] obs, exp;
        logic [31:0] d   [4] = '{32'h11223344, 32'hAABBCCDD, 32'hFFFFFFFF, 32'h0};
        logic [3:0]  e   [4] = '{4'hF, 4'b0101, 4'h0, 4'h0};
        logic        w   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            expect_txn(w[i], 6'd5, d[i], e[i]);
            run_req(1'b0, ~w[i], w[i], 6'd5, d[i], e[i], obs);
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL byte_en_step%0d: got %h expected %h", i, obs, exp);
            end
        end
        checks++;
        if (rdata !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL byte_en_merge: got %h expected 11bb33dd", rdata);
        end
    endtask

    task automatic test_both_strobes();
        logic [40:0] obs, exp;
        int activity;
        @(negedge Clk);
        rd = 1'b1; wr = 1'b1; addr = 6'd5; wdata = 32'hFFFFFFFF; be = 4'hF;
        @(negedge Clk);
        rd = 1'b0; wr = 1'b0;
        checks++;
        if ({err, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL both_strobes_err: got %b expected 100", {err, busy, done});
        end
        activity = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            if (err || busy || done) activity++;
        end
        checks++;
        if (activity !== 0) begin
            errors++;
            $display("FAIL both_strobes_quiet: got %0d active cycles expected 0", activity);
        end
        expect_txn(1'b0, 6'd5, '0, '0);
        run_req(1'b0, 1'b1, 1'b0, 6'd5, '0, '0, obs);
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL both_strobes_array: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_busy_ignore();
        logic [40:0] obs, exp;
        int activity;
        expect_txn(1'b0, 6'd2, '0, '0);
        @(negedge Clk);
        rd = 1'b1; addr = 6'd2;
        @(negedge Clk);
        rd = 1'b0; wr = 1'b1; wdata = 32'h0; be = 4'hF;
        @(negedge Clk);
        @(negedge Clk);
        wr = 1'b0;
        @(negedge Clk);
        obs = pack(rdata, err, done ? 3 : -1);
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL busy_read: got %h expected %h", obs, exp);
        end
        activity = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            if (busy || done) activity++;
        end
        checks++;
        if (activity !== 0) begin
            errors++;
            $display("FAIL busy_ignored: got %0d active cycles expected 0", activity);
        end
        expect_txn(1'b0, 6'd2, '0, '0);
        run_req(1'b0, 1'b1, 1'b0, 6'd2, '0, '0, obs);
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL busy_array: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_back_to_back();
        int first, second;
        first = -1; second = -1;
        @(negedge Clk);
        rd = 1'b1; addr = 6'd2;
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            if (done === 1'b1) begin
                if (first < 0) first = k;
                else begin
                    second = k;
                    break;
                end
            end
        end
        rd = 1'b0;
        checks++;
        if (first !== 3 || second !== 7) begin
            errors++;
            $display("FAIL back_to_back: got done at %0d,%0d expected 3,7", first, second);
        end
        @(negedge Clk);
    endtask

    task automatic test_out_of_range();
        logic [40:0] obs, exp;
        logic        w  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [5:0]  a  [5] = '{6'd47, 6'd47, 6'd50, 6'd50, 6'd48};
        logic [31:0] d  [5] = '{32'h5A5A1234, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0};
        logic        ee [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] rr [5] = '{32'h0, 32'h5A5A1234, 32'h5A5A1234, 32'h5A5A1234, 32'h5A5A1234};
        for (int i = 0; i < 5; i++) exp_q.push_back(pack(rr[i], ee[i], 2));
        for (int i = 0; i < 5; i++) begin
            run_req(1'b1, ~w[i], w[i], a[i], d[i], 4'hF, obs);
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL range_step%0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [40:0] obs, exp;
        int activity;
        @(negedge Clk);
        wr = 1'b1; addr = 6'd3; wdata = 32'hDEADBEEF; be = 4'hF;
        @(negedge Clk);
        wr = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b expected 1", busy);
        end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL mid_abort: got %b expected 00", {busy, done});
        end
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = '0;
        model_rdata = '0;
        activity = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            if (done || busy) activity++;
        end
        checks++;
        if (activity !== 0) begin
            errors++;
            $display("FAIL mid_no_done: got %0d active cycles expected 0", activity);
        end
        for (int i = 2; i < 4; i++) begin
            expect_txn(1'b0, 6'(i), '0, '0);
            run_req(1'b0, 1'b1, 1'b0, 6'(i), '0, '0, obs);
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mid_read%0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rd = 0; wr = 0; addr = 0; wdata = 0; be = 0; mux = 0;
        b_rd = 0; b_wr = 0; b_addr = 0; b_wdata = 0; b_be = 0; b_mux = 0;
        for (int i = 0; i < 64; i++) model[i] = '0;
        model_rdata = '0;
        test_reset();
        test_full_write();
        test_byte_enables();
        test_both_strobes();
        test_busy_ignore();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_lane_dmem.md
# byte_lane_dmem

Parametrised synchronous data memory with a multi-cycle request/done handshake, per-byte write enables and a lane-select display path. It is the next-generation replacement for the fixed 32-bit, 64-word lab memory. It sits between the experiment control logic (switch/CPU-side Mem_Read/Mem_Write strobes) and the board LEDs. Width, depth, display-lane width and access latency are generics.

## Interface
- DATA_W, default 32: word width; multiple of 8 and of LANE_W.
- ADDR_W, default 6: word-address width.
- DEPTH, default 64: number of words; must be ≤ 2^ADDR_W.
- LANE_W, default 8: width of the LED display lane.
- WAIT_CYCLES, default 1: wait states before each access; 0 is legal.
- Clk  in  1: single clock; all state updates on the rising edge.
- Reset  in  1: asynchronous, active-high reset.
- Mem_Read  in  1: read request, sampled in IDLE.
- Mem_Write  in  1: write request, sampled in IDLE.
- Mem_Addr  in  ADDR_W: word address.
- Mem_WData  in  DATA_W: write data.
- Byte_En  in  DATA_W/8: per-byte write enable; bit i covers byte [8i+7:8i].
- MUX  in  clog2(DATA_W/LANE_W), minimum 1: display lane select.
- Mem_RData  out  DATA_W: registered read data.
- Busy  out  1: high while a request is in flight.
- Done  out  1: one-cycle completion pulse.
- Err  out  1: one-cycle error pulse.
- LED  out  LANE_W: lane MUX of Mem_RData.

## Operation
- States:
  - IDLE: waiting for a request.
  - WAIT: counting wait states.
  - ACCESS: performing the array operation.
  - DONE: reporting completion.
- IDLE request handling:
  - Mem_Read XOR Mem_Write high at an edge: the request is accepted and latches Mem_Addr, Mem_WData, Byte_En and the operation type.
  - WAIT_CYCLES > 0 goes to WAIT with the counter set to WAIT_CYCLES-1. WAIT_CYCLES = 0 goes directly to ACCESS.
  - Both strobes high at an edge: no access occurs. Err pulses for one cycle and the state stays IDLE.
- WAIT: the counter decrements each cycle; at 0 the state goes to ACCESS.
- ACCESS, write:
  - Each enabled byte of the latched word is written to the array; disabled bytes keep their value.
  - Byte_En = 0 is legal and completes normally with no change to the array.
- ACCESS, read: the array word is loaded into Mem_RData.
- ACCESS, latched address ≥ DEPTH: the array and Mem_RData are left untouched, and Err pulses together with Done.
- The state always goes from ACCESS to DONE.
- DONE: Done = 1 for one cycle, then the state returns to IDLE.
- Busy = 1 in WAIT, ACCESS and DONE.
- Strobes are ignored while Busy; they are not queued. A strobe held high re-issues the request in the IDLE cycle after DONE.
- Mem_RData holds its value until the next successful read. Writes never alter Mem_RData, even to the same address.
- LED is combinational from Mem_RData and MUX: LED = Mem_RData[MUX*LANE_W +: LANE_W]. A MUX value ≥ DATA_W/LANE_W gives LED = 0.
- Reset:
  - The whole array clears to 0.
  - State returns to IDLE, counter = 0.
  - Mem_RData, Busy, Done, Err and LED all = 0.
  - Reset asserted mid-request aborts it: no partial write and no Done.

## Timing
- Request accepted at edge E0.
- Array write or Mem_RData update occurs at edge E0 + WAIT_CYCLES + 1.
- Done is high during the cycle after edge E0 + WAIT_CYCLES + 2; Mem_RData is valid whenever Done = 1.
- Back-to-back throughput is one request per WAIT_CYCLES + 3 cycles.
- Err for both strobes high is high during the cycle after the sampling edge.
- LED follows MUX with no clock delay and follows Mem_RData at the same edge Mem_RData changes.

## Test plan
- Defaults: after Reset, read address 0 -> Done 3 cycles after acceptance (WAIT_CYCLES = 1), Mem_RData = 0x00000000, LED = 0x00.
- Full write 0xC33C0F81 to address 2 with Byte_En = 4'hF, then read address 2 -> Mem_RData = 0xC33C0F81; MUX = 0/1/2/3 gives LED = 0x81/0x0F/0x3C/0xC3.
- Write 0xAABBCCDD to address 5 with Byte_En = 4'b0101 over prior content 0x11223344 -> read returns 0x11BB33DD. A write with Byte_En = 0 completes with Done and leaves the word unchanged.
- Mem_Read and Mem_Write both high -> Err pulse for 1 cycle, no Busy, no Done, array unchanged. A strobe asserted while Busy -> ignored.
- DEPTH = 48, read address 50 -> Err and Done together, Mem_RData retains its previous value. With WAIT_CYCLES = 0, a read completes with Done 2 cycles after acceptance.
- Reset asserted during WAIT of a write to address 3 -> Busy = 0 immediately, no Done; a subsequent read of address 3 returns 0.
